// File: rtl/ect_switch_pkg.sv
// Shared types and constants for the ECT electrode switch loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, frame width, 2-bit electrode codes, all-GND default pattern.
package ect_switch_pkg;

  localparam int SWITCH_FRAME_BITS = 64;

  // Two bits per electrode, MSB-first in the frame.
  localparam logic [1:0] SW_EXC  = 2'b11;
  localparam logic [1:0] SW_MEAS = 2'b00;
  localparam logic [1:0] SW_GND  = 2'b10;

  localparam logic [SWITCH_FRAME_BITS-1:0] SW_PATTERN_ALL_GND =
    {(SWITCH_FRAME_BITS / 2){SW_GND}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_SETTLE,
    ST_DONE
  } sw_state_e;

endpackage

// File: rtl/switch_sclk_gen.sv
// Serial clock generator: CLK_DIV-cycle low phase followed by CLK_DIV-cycle high phase.
// Latency: sclk falls on the first enabled cycle; strobes flag the last cycle of each phase.
// Backpressure: none; free-running while en=1, cleared and idling high while en=0.
// Ports: clk, rst_n (async active-low), en (SHIFT state), sclk,
//        rise_stb (last low-phase cycle: sclk rises at the next edge),
//        fall_stb (last high-phase cycle: sclk falls at the next edge).
import ect_switch_pkg::*;

module switch_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] phase_q;
  logic          high_q;
  logic          phase_last;

  assign phase_last = (phase_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      high_q  <= 1'b0;
    end else if (!en) begin
      // Held cleared so every enable starts with a fresh low phase.
      phase_q <= '0;
      high_q  <= 1'b0;
    end else if (phase_last) begin
      phase_q <= '0;
      high_q  <= ~high_q;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign sclk     = en ? high_q : 1'b1;
  assign rise_stb = en && !high_q && phase_last;
  assign fall_stb = en &&  high_q && phase_last;

endmodule

// File: rtl/switch_serial_loader.sv
// Loads one 64-bit electrode switch pattern MSB-first into the daisy-chained switch array.
// Latency: Done pulses 1 + 129*CLK_DIV + SETTLE_CYC cycles after the accepting edge.
// Backpressure: Start is only honoured in IDLE (Busy=0); Abort returns to IDLE next cycle.
// Ports: clk, rst_n (async active-low), start, switch_data[63:0], abort, sw_dout (chain return);
//        busy, done, sw_sclk, sw_din, sw_sync_n, readback_err.
// Option: define SWITCH_READBACK_EN to compare the chain return against the previous frame.
import ect_switch_pkg::*;

module switch_serial_loader #(
  parameter int CLK_DIV    = 4,
  parameter int SETTLE_CYC = 200,
  parameter int DATA_W     = SWITCH_FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] switch_data,
  input  logic              abort,
  input  logic              sw_dout,
  output logic              busy,
  output logic              done,
  output logic              sw_sclk,
  output logic              sw_din,
  output logic              sw_sync_n,
  output logic              readback_err
);

  localparam int TW_DIV = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW_SET = $clog2(SETTLE_CYC + 1);
  localparam int TW     = (TW_SET > TW_DIV) ? TW_SET : TW_DIV;
  localparam logic [6:0] LAST_BIT = 7'(DATA_W - 1);

  sw_state_e         state_q, state_d;
  logic [TW-1:0]     tmr_q;
  logic [6:0]        bit_q;
  logic [DATA_W-1:0] sreg_q;

  logic gen_sclk, sclk_rise, sclk_fall;
  logic div_last, settle_last, accept, aborting, frame_act;

  assign div_last    = (tmr_q == TW'(CLK_DIV - 1));
  assign settle_last = (tmr_q == TW'(SETTLE_CYC - 1));
  assign accept      = (state_q == ST_IDLE) && start && !abort;
  assign aborting    = (state_q != ST_IDLE) && abort;

  switch_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == ST_SHIFT),
    .sclk     (gen_sclk),
    .rise_stb (sclk_rise),
    .fall_stb (sclk_fall)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  if (div_last) state_d = ST_SHIFT;
      // Bit 0 ends on its low phase; HOLD supplies the final high time.
      ST_SHIFT:  if (sclk_rise && (bit_q == LAST_BIT)) state_d = ST_HOLD;
      ST_HOLD:   if (div_last) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (aborting) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= SW_PATTERN_ALL_GND;
    end else begin
      state_q <= state_d;
      // Shared SETUP/HOLD/SETTLE timer, restarted on every state change.
      tmr_q   <= (state_d != state_q) ? '0 : tmr_q + 1'b1;

      if (state_q != ST_SHIFT) bit_q <= '0;
      else if (sclk_rise && (bit_q != LAST_BIT)) bit_q <= bit_q + 1'b1;

      if (accept) sreg_q <= switch_data;
      else if ((state_q == ST_SHIFT) && sclk_rise && (bit_q != LAST_BIT))
        sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
    end
  end

  assign frame_act = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign sw_sync_n = !frame_act;
  assign sw_sclk   = (state_q == ST_SHIFT) ? gen_sclk : 1'b1;
  assign sw_din    = frame_act ? sreg_q[DATA_W-1] : 1'b0;

`ifdef SWITCH_READBACK_EN
  logic [DATA_W-1:0] cap_q, frame_q, prev_q;
  logic              prev_vld_q, err_q;
  logic              rb_sample, hold_exit;

  // The chain return is taken on every SwSclk falling edge: SETUP->SHIFT and each high-phase end.
  assign rb_sample = ((state_q == ST_SETUP) && div_last) || ((state_q == ST_SHIFT) && sclk_fall);
  assign hold_exit = (state_q == ST_HOLD) && (state_d == ST_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q      <= '0;
      frame_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (rb_sample) cap_q <= {cap_q[DATA_W-2:0], sw_dout};
      if (accept) frame_q <= switch_data;
      // A discarded frame leaves the chain contents unknown; skip the next compare.
      if (aborting) prev_vld_q <= 1'b0;
      else if (hold_exit) begin
        if (prev_vld_q) err_q <= (cap_q != prev_q);
        prev_q     <= frame_q;
        prev_vld_q <= 1'b1;
      end
    end
  end

  assign readback_err = err_q;
`else
  logic unused_rb;
  assign unused_rb    = sw_dout ^ sclk_fall;
  assign readback_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_serial_loader.sv
// Self-checking bench for switch_serial_loader: default instance plus a CLK_DIV=2/SETTLE_CYC=1 instance.
// Latency: n/a.  Backpressure: n/a.
// Frames are observed at the serial pins and compared against pattern/timing rules computed here.
module tb_switch_serial_loader;
  import ect_switch_pkg::*;

  localparam int CD  = 4;
  localparam int SC  = 200;
  localparam int CD2 = 2;
  localparam int SC2 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, sw_dout;
  logic [63:0] switch_data;
  logic        busy, done, sw_sclk, sw_din, sw_sync_n, readback_err;

  logic        start2, abort2, sw_dout2;
  logic [63:0] data2;
  logic        busy2, done2, sclk2, din2, sync2_n, err2;

  int vectors = 0;
  int miscompares = 0;

  // Daisy-chain model: the array shifts SwDin in on each SwSclk fall; return is its MSB.
  logic [63:0] dev = '0;
  bit          flip_req = 1'b0;
  bit          flip_done = 1'b0;

  always #5 clk = ~clk;

  always @(negedge sw_sclk) begin
    dev = {dev[62:0], sw_din};
    if (flip_req && !flip_done) begin
      dev[63] = ~dev[63];
      flip_done = 1'b1;
    end
  end
  assign sw_dout = dev[63];

  switch_serial_loader #(.CLK_DIV(CD), .SETTLE_CYC(SC), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .switch_data(switch_data), .abort(abort),
    .sw_dout(sw_dout), .busy(busy), .done(done), .sw_sclk(sw_sclk), .sw_din(sw_din),
    .sw_sync_n(sw_sync_n), .readback_err(readback_err)
  );

  switch_serial_loader #(.CLK_DIV(CD2), .SETTLE_CYC(SC2), .DATA_W(64)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start2), .switch_data(data2), .abort(abort2),
    .sw_dout(sw_dout2), .busy(busy2), .done(done2), .sw_sclk(sclk2), .sw_din(din2),
    .sw_sync_n(sync2_n), .readback_err(err2)
  );

  // Request a frame; returns 1 time unit after the accepting edge.
  task automatic issue(input int which, input logic [63:0] p);
    @(negedge clk);
    if (which == 0) begin switch_data = p; start = 1'b1; end
    else begin data2 = p; start2 = 1'b1; end
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  // Watches one frame cycle by cycle (c=1 is the cycle after acceptance) until the cycle after Done.
  task automatic observe(input int which, input int budget, input bit scramble,
                         output int falls, output logic [63:0] bits, output int sync_low,
                         output int done_c, output int done_cnt, output logic busy_first,
                         output logic busy_after, output bit timeout);
    logic prev_sclk, s_sclk, s_din, s_sync, s_busy, s_done;
    falls = 0; bits = '0; sync_low = 0; done_c = -1; done_cnt = 0;
    busy_first = 1'b0; busy_after = 1'b1; timeout = 1'b1; prev_sclk = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (scramble) switch_data = {$urandom, $urandom};
      s_sclk = (which == 0) ? sw_sclk   : sclk2;
      s_din  = (which == 0) ? sw_din    : din2;
      s_sync = (which == 0) ? sw_sync_n : sync2_n;
      s_busy = (which == 0) ? busy      : busy2;
      s_done = (which == 0) ? done      : done2;
      if (c == 1) busy_first = s_busy;
      if (!s_sync) sync_low++;
      if (prev_sclk && !s_sclk) begin
        falls++;
        bits = {bits[62:0], s_din};
      end
      prev_sclk = s_sclk;
      if (s_done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        busy_after = s_busy;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    vectors++;
    if ({sw_sclk, sw_sync_n, sw_din, busy, done, readback_err} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 110000",
               {sw_sclk, sw_sync_n, sw_din, busy, done, readback_err});
    end
    vectors++;
    if ({sclk2, sync2_n, din2, busy2, done2, err2} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_outputs_fast: got %b want 110000", {sclk2, sync2_n, din2, busy2, done2, err2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [63:0] p, bits, gnd_pat;
    int falls, sl, dc, dn;
    logic bf, ba;
    bit to;
    gnd_pat = SW_PATTERN_ALL_GND;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) p = {gnd_pat[63:4], SW_MEAS, SW_EXC};
      else if (i == 1) p = {16{SW_EXC, SW_MEAS}};
      else p = {$urandom, $urandom};
      issue(0, p);
      observe(0, 1000, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL frame%0d_timeout: no Done within 1000 cycles", i); end
      vectors++;
      if (falls != 64) begin miscompares++; $display("FAIL frame%0d_falls: got %0d want 64", i, falls); end
      vectors++;
      if (bits !== p) begin miscompares++; $display("FAIL frame%0d_bits: got %h want %h", i, bits, p); end
      vectors++;
      if (sl != 129 * CD) begin miscompares++; $display("FAIL frame%0d_sync_low: got %0d want %0d", i, sl, 129 * CD); end
      vectors++;
      if (dc != 1 + 129 * CD + SC) begin
        miscompares++; $display("FAIL frame%0d_done_cycle: got %0d want %0d", i, dc, 1 + 129 * CD + SC);
      end
      vectors++;
      if ({bf, ba, dn == 1} !== 3'b101) begin
        miscompares++; $display("FAIL frame%0d_busy_done: busy_first=%b busy_after=%b done_pulses=%0d want 1 0 1", i, bf, ba, dn);
      end
    end
  endtask

  task automatic test_start_held();
    logic [63:0] p1, p2, bits;
    int falls, sl, dc, dn;
    logic bf, ba;
    bit to;
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    @(negedge clk);
    switch_data = p1;
    start = 1'b1;
    @(posedge clk);
    #1;
    observe(0, 1000, 1'b1, falls, bits, sl, dc, dn, bf, ba, to);
    vectors++;
    if (bits !== p1 || falls != 64) begin
      miscompares++; $display("FAIL held_first_bits: got %h (%0d falls) want %h (64)", bits, falls, p1);
    end
    vectors++;
    if (dn != 1 || ba !== 1'b0 || to) begin
      miscompares++; $display("FAIL held_single_frame: done_pulses=%0d busy_after=%b timeout=%b want 1 0 0", dn, ba, to);
    end
    // Start is still high: accepted at the next edge now that Busy is low.
    switch_data = p2;
    @(posedge clk);
    #1;
    start = 1'b0;
    observe(0, 1000, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
    vectors++;
    if (bits !== p2 || bf !== 1'b1) begin
      miscompares++; $display("FAIL held_second_frame: got %h busy_first=%b want %h 1", bits, bf, p2);
    end
    vectors++;
    if (dc != 1 + 129 * CD + SC) begin
      miscompares++; $display("FAIL held_second_done: got %0d want %0d", dc, 1 + 129 * CD + SC);
    end
  endtask

  task automatic test_abort();
    logic [63:0] p, bits;
    int falls, sl, dc, dn, busy_seen;
    logic bf, ba, prev;
    bit to;
    // Abort overrides a simultaneous Start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_beats_start: busy got %b want 0", busy); end

    p = {$urandom, $urandom};
    issue(0, p);
    prev = 1'b1;
    falls = 0;
    for (int c = 0; c < 3000 && falls < 31; c++) begin
      @(negedge clk);
      if (prev && !sw_sclk) falls++;
      prev = sw_sclk;
    end
    vectors++;
    if (falls != 31) begin miscompares++; $display("FAIL abort_reach_bit30: got %0d falls want 31", falls); end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sw_sclk, sw_sync_n, sw_din, busy, done} !== 5'b11000) begin
      miscompares++; $display("FAIL abort_outputs: got %b want 11000", {sw_sclk, sw_sync_n, sw_din, busy, done});
    end
    dn = 0; busy_seen = 0;
    repeat (800) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) busy_seen++;
    end
    vectors++;
    if (dn != 0 || busy_seen != 0) begin
      miscompares++; $display("FAIL abort_no_done: done=%0d busy_cycles=%0d want 0 0", dn, busy_seen);
    end
    p = {$urandom, $urandom};
    issue(0, p);
    observe(0, 1000, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
    vectors++;
    if (bits !== p || falls != 64 || dc != 1 + 129 * CD + SC) begin
      miscompares++; $display("FAIL abort_refill: got %h falls=%0d done=%0d want %h 64 %0d", bits, falls, dc, p, 1 + 129 * CD + SC);
    end
  endtask

  task automatic test_async_reset();
    int dn, busy_seen;
    issue(0, {$urandom, $urandom});
    repeat (620) @(negedge clk);
    vectors++;
    if ({busy, sw_sync_n, done} !== 3'b110) begin
      miscompares++; $display("FAIL rst_in_settle: busy,sync_n,done got %b want 110", {busy, sw_sync_n, done});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sw_sclk, sw_sync_n, sw_din, busy, done, readback_err} !== 6'b110000) begin
      miscompares++; $display("FAIL rst_async_outputs: got %b want 110000",
                              {sw_sclk, sw_sync_n, sw_din, busy, done, readback_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0; busy_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) busy_seen++;
    end
    vectors++;
    if (dn != 0 || busy_seen != 0) begin
      miscompares++; $display("FAIL rst_no_done: done=%0d busy_cycles=%0d want 0 0", dn, busy_seen);
    end
  endtask

  task automatic test_readback();
    logic [63:0] p, bits;
    int falls, sl, dc, dn;
    logic bf, ba;
    bit to;
`ifdef SWITCH_READBACK_EN
    logic exp_err [4];
    exp_err = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 4; f++) begin
      p = (f == 0) ? 64'hAAAAAAAAAAAAA3A3 : {$urandom, $urandom};
      // Frame 2 gets one corrupted bit back from the chain.
      if (f == 2) flip_req = 1'b1;
      issue(0, p);
      observe(0, 1000, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
      vectors++;
      if (readback_err !== exp_err[f] || to) begin
        miscompares++; $display("FAIL readback_frame%0d: err got %b want %b (timeout=%b)", f, readback_err, exp_err[f], to);
      end
    end
`else
    p = 64'hAAAAAAAAAAAAA3A3;
    issue(0, p);
    observe(0, 1000, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
    vectors++;
    if (readback_err !== 1'b0 || bits !== p) begin
      miscompares++; $display("FAIL readback_off: err=%b bits=%h want 0 %h", readback_err, bits, p);
    end
`endif
  endtask

  task automatic test_fast_config();
    logic [63:0] p, bits;
    int falls, sl, dc, dn;
    logic bf, ba;
    bit to;
    for (int i = 0; i < 2; i++) begin
      p = {$urandom, $urandom};
      issue(1, p);
      observe(1, 400, 1'b0, falls, bits, sl, dc, dn, bf, ba, to);
      vectors++;
      if (bits !== p || falls != 64) begin
        miscompares++; $display("FAIL fast%0d_bits: got %h (%0d falls) want %h (64)", i, bits, falls, p);
      end
      vectors++;
      if (sl != 129 * CD2) begin miscompares++; $display("FAIL fast%0d_sync_low: got %0d want %0d", i, sl, 129 * CD2); end
      vectors++;
      if (dc != 1 + 129 * CD2 + SC2 || ba !== 1'b0) begin
        miscompares++; $display("FAIL fast%0d_done: cycle %0d busy_after %b want %0d 0", i, dc, ba, 1 + 129 * CD2 + SC2);
      end
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; switch_data = '0;
    start2 = 1'b0; abort2 = 1'b0; data2 = '0; sw_dout2 = 1'b0;
    test_reset();
    test_frame();
    test_start_held();
    test_abort();
    test_async_reset();
    test_readback();
    test_fast_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_serial_loader.md
# switch_serial_loader

Serialises one 64-bit electrode switch pattern (2 bits per electrode: 11 excitation, 00 measure, 10 GND) into the daisy-chained analog switch array of the ECT front end. Sits directly downstream of the switch-pattern selector: accepts a parallel pattern on a start strobe, shifts it MSB-first under a frame sync, then holds off for a settling window before reporting done to the measurement sequencer.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; legal range ≥ 2
- SETTLE_CYC, 200: clocks after frame end before Done; legal range ≥ 1
- DATA_W, 64: pattern width; fixed at 64
- Clk  in  1  system clock; all logic on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  load request; sampled only in IDLE
- SwitchData  in  64  pattern; captured on the accepted Start cycle
- Abort  in  1  synchronous abort; overrides Start
- SwDout  in  1  daisy-chain return (used only with readback)
- Busy  out  1  high from cycle after Start acceptance through the Done cycle
- Done  out  1  one-cycle pulse at end of settling
- SwSclk  out  1  switch serial clock; idles high
- SwDin  out  1  switch serial data
- SwSync_n  out  1  frame sync, low during shifting
- ReadbackErr  out  1  readback mismatch flag (tied 0 without readback)

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, SETTLE, DONE.
- IDLE: Start=1 and Abort=0 → capture SwitchData into shift register, go to SETUP. Start in any other state is ignored.
- SETUP (CLK_DIV cycles): SwSync_n=0, SwSclk=1, SwDin=bit 63.
- SHIFT: 64 bit periods of 2·CLK_DIV cycles: SwSclk low CLK_DIV cycles (switch samples on falling edge), then high CLK_DIV cycles. SwDin advances to next lower bit at the low→high transition. After bit 0's low phase → HOLD.
- HOLD (CLK_DIV cycles): SwSclk=1, SwSync_n=0; then SwSync_n rises (switch update) → SETTLE.
- SETTLE: SETTLE_CYC cycles, all serial outputs idle → DONE.
- DONE: Done=1 for one cycle, Busy still 1 → IDLE.
- Abort=1 in any non-IDLE state: next cycle IDLE, SwSync_n=1, SwSclk=1, SwDin=0, Busy=0, no Done pulse; partial frame discarded (switches keep old state since sync rising edge with incomplete frame is ignored by the device only if count ≠ 64 — sequencer must reissue Start).
- SwitchData changes after acceptance have no effect on the frame in flight.

## Timing
- Reset values: SwSclk=1, SwSync_n=1, SwDin=0, Busy=0, Done=0, ReadbackErr=0, state IDLE.
- Start accepted at edge k: SwSync_n low and Busy high from cycle k+1.
- SwSync_n low for CLK_DIV·129 cycles (516 at default).
- Done at cycle k+1+129·CLK_DIV+SETTLE_CYC (717 at defaults); Busy falls the following cycle; Start in that next cycle accepted.
- Start coincident with Done: ignored (Busy=1).
- Counters: phase counter $clog2(CLK_DIV), bit counter 7 bits (0..63, no wrap), settle counter $clog2(SETTLE_CYC+1); all cleared on entering their state.
- Rst_n low mid-frame: outputs go to reset values immediately (asynchronous).

## Configuration
- SWITCH_READBACK_EN defined: SwDout sampled at each SwSclk falling edge into a 64-bit register; at HOLD exit compared against the previous completed frame's pattern. ReadbackErr updated at that point (1 = mismatch) and held until the next frame end. First frame after reset or after Abort performs no comparison (ReadbackErr stays unchanged).
- Not defined: SwDout unused, no capture/compare registers, ReadbackErr constant 0.

## Structure
- Package ect_switch_pkg: state enum, SWITCH_FRAME_BITS=64, electrode code constants (EXC=2'b11, MEAS=2'b00, GND=2'b10), all-GND default pattern 64'hAAAAAAAAAAAAAAAA.
- One sub-module: switch_sclk_gen — phase counter producing SwSclk plus one-cycle fall/rise strobes, enabled only in SHIFT.

## Test plan
- Reset then Start with 64'hAAAAAAAAAAAAAAA3 → 64 falling edges, SwDin at falls reproduces pattern MSB-first, SwSync_n low 516 cycles, Done at cycle k+717.
- Start held high through entire frame with changing SwitchData → exactly one frame of the captured value, second Start accepted only after Busy falls.
- Abort at bit 30 → next cycle IDLE, SwSync_n=1, Busy=0, no Done; new Start gives full 64-bit frame.
- Rst_n asserted at SETTLE mid-count → outputs at reset values same cycle, no Done after release.
- With SWITCH_READBACK_EN: frames A=64'hAAAAAAAAAAAAA3A3 then B; loop SwDout to delayed SwDin model → ReadbackErr=0; flip one returned bit → ReadbackErr=1 at frame-B end.
- CLK_DIV=2, SETTLE_CYC=1 → SwSync_n low 258 cycles, Done at k+260.
